// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle over unsigned
// magnitudes, with sign correction and special-case results applied on completion.
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int DATA_W = 32;
  localparam int STAGES = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state;
  logic        [2:0]         op_p0;
  logic                      neg_p0;
  logic                      dz_p0;
  logic                      ovf_p0;
  logic        [5:0]         cnt_p0;
  logic        [2*DATA_W-1:0] acc_p0;
  logic        [DATA_W-1:0]  b_p0;
  logic signed [DATA_W-1:0]  op1_p0;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  logic              is_div_in, s1_in, s2_in, neg_in, dz_in, ovf_in;
  logic [DATA_W-1:0] mag1_in, mag2_in;

  always_comb begin
    is_div_in = funct3_i[2];
    s1_in     = op1_i[31] & (is_div_in ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
    s2_in     = op2_i[31] & (is_div_in ? ~funct3_i[0] : ~funct3_i[1]);
    // Remainder follows the dividend; product and quotient follow both operands.
    neg_in    = (is_div_in & funct3_i[1]) ? s1_in : (s1_in ^ s2_in);
    dz_in     = is_div_in & (op2_i == 32'd0);
    ovf_in    = is_div_in & ~funct3_i[0] & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
    mag1_in   = neg32(op1_i, s1_in);
    mag2_in   = neg32(op2_i, s2_in);
  end

  logic [DATA_W:0]       mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0]   step_acc, prod;
  logic [DATA_W-1:0]     res_final;

  always_comb begin
    mul_sum   = {1'b0, acc_p0[63:32]} + (acc_p0[0] ? {1'b0, b_p0} : 33'd0);
    div_shift = {acc_p0[63:32], acc_p0[31]};
    div_diff  = div_shift - {1'b0, b_p0};
    if (op_p0[2]) begin
      if (!div_diff[DATA_W])
        step_acc = {div_diff[31:0], acc_p0[30:0], 1'b1};
      else
        step_acc = {div_shift[31:0], acc_p0[30:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc_p0[31:1]};
    end

    prod = neg64(step_acc, neg_p0);
    if (!op_p0[2])
      res_final = (op_p0[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    else if (dz_p0)
      res_final = op_p0[1] ? op1_p0 : 32'hFFFF_FFFF;
    else if (ovf_p0)
      res_final = op_p0[1] ? 32'd0 : 32'h8000_0000;
    else
      res_final = neg32(op_p0[1] ? step_acc[63:32] : step_acc[31:0], neg_p0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      op_p0    <= '0;
      neg_p0   <= 1'b0;
      dz_p0    <= 1'b0;
      ovf_p0   <= 1'b0;
      cnt_p0   <= '0;
      acc_p0   <= '0;
      b_p0     <= '0;
      op1_p0   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          if (start_i && !flush_i) begin
            state  <= CALC;
            busy_o <= 1'b1;
            op_p0  <= funct3_i;
            neg_p0 <= neg_in;
            dz_p0  <= dz_in;
            ovf_p0 <= ovf_in;
            cnt_p0 <= '0;
            op1_p0 <= op1_i;
            // Multiply walks the multiplier bits; divide shifts the dividend out.
            acc_p0 <= {32'd0, is_div_in ? mag1_in : mag2_in};
            b_p0   <= is_div_in ? mag2_in : mag1_in;
          end
        end
        CALC: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            acc_p0 <= step_acc;
            cnt_p0 <= cnt_p0 + 6'd1;
            if (cnt_p0 == 6'(STAGES - 1)) begin
              state    <= DONE;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              result_o <= res_final;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table, random ops against an arithmetic model,
// and hand-written flush / start / reset sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(f3),
    .op1_i(op1), .op2_i(op2), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Entered mid-cycle; leaves at the negedge of cycle T+34 so the next call starts at T+34.
  task automatic run_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_n, done_n, done_at;
    logic [31:0] res;
    busy_n = 0; done_n = 0; done_at = 0; res = '0;
    f3 = fn; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        res = result;
      end
    end
    check({name, " result"}, res, exp);
    check({name, " done_cycle"}, 32'(done_at), 32'd33);
    check({name, " done_count"}, 32'(done_n), 32'd1);
    check({name, " busy_cycles"}, 32'(busy_n), 32'd32);
    last_exp = exp;
  endtask

  vec_t vecs[$];

  initial begin
    int busy_n, done_n, done_at;
    logic [31:0] res;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; op1 = '0; op2 = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{"mul_7_m3",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"mulh_min_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{"mulhu_max",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"mulhsu_max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{"rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{"divu_max_2",     3'd5, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF});
    vecs.push_back('{"div_100_0",      3'd4, 32'd100,        32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"remu_100_0",     3'd7, 32'd100,        32'd0,          32'd100});
    vecs.push_back('{"div_neg_0",      3'd4, 32'hFFFF_FF9C, 32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"rem_neg_0",      3'd6, 32'hFFFF_FF9C, 32'd0,          32'hFFFF_FF9C});
    vecs.push_back('{"div_ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"rem_ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{"b2b_mul",        3'd0, 32'd1234,       32'd5678,       32'd7006652});
    vecs.push_back('{"b2b_divu",       3'd5, 32'd1000,       32'd7,          32'd142});
    vecs.push_back('{"remu_1000_7",    3'd7, 32'd1000,       32'd7,          32'd6});
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush at T+10: busy drops at T+11, no done through T+40, result held.
    f3 = 3'd0; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy_drop", {31'd0, busy}, 32'd0);
    done_n = 0; busy_n = 0;
    for (int k = 12; k <= 40; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("flush no_done", 32'(done_n), 32'd0);
    check("flush no_busy", 32'(busy_n), 32'd0);
    check("flush result_held", result, last_exp);

    // Start held through CALC with changing inputs: only the first op runs.
    f3 = 3'd0; op1 = 32'd6; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 f3 = 3'd5; op1 = 32'd99; op2 = 32'd3;
    done_n = 0; busy_n = 0; done_at = 0; res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = k; res = result; end
    end
    check("hold_start result", res, 32'd42);
    check("hold_start done_cycle", 32'(done_at), 32'd33);
    check("hold_start done_count", 32'(done_n), 32'd1);
    check("hold_start busy_cycles", 32'(busy_n), 32'd32);
    last_exp = 32'd42;

    // Start and flush together in IDLE: nothing starts.
    f3 = 3'd0; op1 = 32'd2; op2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    done_n = 0; busy_n = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
    end
    check("start_flush busy", 32'(busy_n), 32'd0);
    check("start_flush done", 32'(done_n), 32'd0);
    check("start_flush result", result, last_exp);

    // Asynchronous reset at T+20 between clock edges.
    f3 = 3'd5; op1 = 32'd500; op2 = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", {31'd0, busy}, 32'd0);
    check("async_rst done", {31'd0, done}, 32'd0);
    check("async_rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("async_rst no_done", 32'(done_n), 32'd0);
    check("async_rst no_busy", 32'(busy_n), 32'd0);

    // Random ops against the arithmetic model, with special operands mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, model(rf, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the execute stage, in parallel with the single-cycle ALU. It takes the same forwarded operand pair the ALU receives. Its 32-bit result is muxed with the ALU result into the EX/MEM register. The pipeline stalls on `busy_o` and advances when `done_o` pulses.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clk_i` input 1: single clock, all state on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: request; sampled only in IDLE.
- `funct3_i` input 3: op select, sampled with `start_i`.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1_i` input 32: rs1 value (multiplicand / dividend), sampled with `start_i`.
- `op2_i` input 32: rs2 value (multiplier / divisor), sampled with `start_i`.
- `flush_i` input 1: kill the in-flight operation (branch mispredict / trap).
- `busy_o` output 1: high while iterating; pipeline stall request.
- `done_o` output 1: one-cycle pulse; `result_o` valid in that cycle.
- `result_o` output 32: final result; holds until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start_i`=1 and `flush_i`=0 leads to CALC, and at the same edge:
  - latches `funct3_i`;
  - latches operand magnitudes and result sign;
  - clears the 6-bit iteration counter.
- Otherwise IDLE stays in IDLE.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
  - After the 32nd step, go to DONE.
- Operand sign handling:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Signed operands are converted to magnitudes and iterated unsigned. Sign correction is a two's-complement negate applied on the CALC→DONE edge.
  - Product sign = XOR of operand signs.
  - Quotient sign = XOR of operand signs.
  - Remainder sign = dividend sign.
- Result select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Divide by zero (op2=0):
  - quotient = 0xFFFFFFFF for DIV and DIVU;
  - remainder = op1 unchanged for REM and REMU.
- Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Both special cases still take the full latency (uniform timing); the result override is applied at the CALC→DONE edge.
- DONE: `done_o`=1 for exactly one cycle, `result_o` updated; then IDLE unconditionally.
- `start_i` in CALC or DONE is ignored; no queuing.
- `flush_i` in CALC or DONE forces IDLE at the next edge.
  - The killed operation never raises `done_o`.
  - `result_o` keeps its previous value.
- `flush_i` and `start_i` both high in IDLE: flush wins, no operation starts.

## Timing
- Reset (async assert, any state):
  - state=IDLE, `busy_o`=0, `done_o`=0, `result_o`=0;
  - counter and datapath registers cleared.
- Reset mid-operation: the operation is abandoned and no `done_o` follows.
- `start_i` accepted in cycle T gives:
  - `busy_o`=1 in cycles T+1 to T+32;
  - `done_o`=1 and `result_o` valid in cycle T+33;
  - IDLE in cycle T+34.
- Earliest next accepted start is T+34.
- `busy_o` is 0 in IDLE and in DONE. `done_o` is 0 in every cycle except DONE.
- `result_o` changes only on the CALC→DONE edge or on reset.
- `flush_i` sampled high in a CALC cycle gives `busy_o`=0 in the following cycle.

## Test plan
- MUL, op1=7, op2=0xFFFFFFFD (-3), start at T → `done_o` at T+33 only, `result_o`=0xFFFFFFEB, `busy_o` high for exactly 32 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- Divide by zero:
  - DIV 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, both at T+33.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush and start interaction:
  - Start at T, `flush_i` at T+10 → `busy_o`=0 at T+11, no `done_o` through T+40, `result_o` unchanged.
  - `start_i` held high during CALC is ignored.
  - `start_i` and `flush_i` together in IDLE → no start.
- Reset and back-to-back ops:
  - Assert `rst_i` asynchronously at T+20 → outputs zero immediately, no `done_o` afterwards.
  - Back-to-back MUL then DIVU with starts at T and T+34 → both complete with correct results at T+33 and T+67.
